// File: rtl/aes_key_expansion.sv
// Iterative AES-128 key schedule: one round key per i_next, four 32-bit words,
// computed on the fly from the currently held key with no stored schedule.

module aes_sbox (
  input  logic [0:7] i_byte,
  output logic [0:7] o_byte
);
  // FIPS-197 forward S-box, entry n occupies bits [8n : 8n+7].
  localparam logic [0:2047] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  logic [10:0] idx;
  assign idx    = {i_byte, 3'b000};
  assign o_byte = SBOX_TABLE[idx +: 8];
endmodule

module aes_key_expansion (
  input  logic         i_clock,
  input  logic         i_reset,
  input  logic         i_start,
  input  logic [0:127] i_key,
  input  logic         i_next,
  output logic [0:31]  o_key0,
  output logic [0:31]  o_key1,
  output logic [0:31]  o_key2,
  output logic [0:31]  o_key3,
  output logic [0:3]   o_round,
  output logic         o_valid,
  output logic         o_last,
  output logic         o_state
);
  // Handshake: i_start loads i_key (round 0) in any state and wins over i_next;
  // i_next in ACTIVE advances one round per cycle, and from round 10 drops to IDLE.
  // The consumer samples the words in the cycle it raises i_next.
  typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} state_t;

  state_t      state_q, state_d;
  logic [0:31] w0_q, w1_q, w2_q, w3_q;
  logic [0:31] w0_d, w1_d, w2_d, w3_d;
  logic [0:3]  round_q, round_d;
  logic        last_q, last_d;

  logic [0:7]  rcon;
  logic [0:31] rot_w, sub_w, t_w;
  logic [0:31] n0, n1, n2, n3;

  // Rcon for the round being produced (round_q + 1).
  always_comb begin
    rcon = 8'h00;
    case (round_q)
      4'd0:    rcon = 8'h01;
      4'd1:    rcon = 8'h02;
      4'd2:    rcon = 8'h04;
      4'd3:    rcon = 8'h08;
      4'd4:    rcon = 8'h10;
      4'd5:    rcon = 8'h20;
      4'd6:    rcon = 8'h40;
      4'd7:    rcon = 8'h80;
      4'd8:    rcon = 8'h1b;
      4'd9:    rcon = 8'h36;
      default: rcon = 8'h00;
    endcase
  end

  assign rot_w = {w3_q[8:31], w3_q[0:7]};

  aes_sbox u_sbox0 (.i_byte(rot_w[0:7]),   .o_byte(sub_w[0:7]));
  aes_sbox u_sbox1 (.i_byte(rot_w[8:15]),  .o_byte(sub_w[8:15]));
  aes_sbox u_sbox2 (.i_byte(rot_w[16:23]), .o_byte(sub_w[16:23]));
  aes_sbox u_sbox3 (.i_byte(rot_w[24:31]), .o_byte(sub_w[24:31]));

  assign t_w = sub_w ^ {rcon, 24'h000000};
  assign n0  = w0_q ^ t_w;
  assign n1  = w1_q ^ n0;
  assign n2  = w2_q ^ n1;
  assign n3  = w3_q ^ n2;

  always_comb begin
    state_d = state_q;
    w0_d    = w0_q;
    w1_d    = w1_q;
    w2_d    = w2_q;
    w3_d    = w3_q;
    round_d = round_q;
    if (i_start) begin
      state_d = ACTIVE;
      w0_d    = i_key[0:31];
      w1_d    = i_key[32:63];
      w2_d    = i_key[64:95];
      w3_d    = i_key[96:127];
      round_d = 4'd0;
    end else if (state_q == ACTIVE && i_next) begin
      if (round_q == 4'd10) begin
        // Words and round index stay on their final values after the schedule ends.
        state_d = IDLE;
      end else begin
        w0_d    = n0;
        w1_d    = n1;
        w2_d    = n2;
        w3_d    = n3;
        round_d = round_q + 4'd1;
      end
    end
    last_d = (state_d == ACTIVE) && (round_d == 4'd10);
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q <= IDLE;
      w0_q    <= '0;
      w1_q    <= '0;
      w2_q    <= '0;
      w3_q    <= '0;
      round_q <= '0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      w0_q    <= w0_d;
      w1_q    <= w1_d;
      w2_q    <= w2_d;
      w3_q    <= w3_d;
      round_q <= round_d;
      last_q  <= last_d;
    end
  end

  assign o_key0  = w0_q;
  assign o_key1  = w1_q;
  assign o_key2  = w2_q;
  assign o_key3  = w3_q;
  assign o_round = round_q;
  assign o_valid = (state_q == ACTIVE);
  assign o_last  = last_q;
  assign o_state = state_q;
endmodule
